width_gearbox: RTL

Byte-granular stream width converter for arbitrary input/output widths: any multiple of 8, with no integer-ratio requirement (e.g. 24→32, 40→16). Input bytes are packed into a shift buffer and emitted as full output words. Partial input beats (short strobe) are compacted, and a packet tail is flushed with a partial strobe and `dout_last`. It sits on the same valid/ready/strb/last streams as the existing up/down converters and replaces them where the width ratio is non-integer or partial beats occur mid-packet.

---
 rtl/width_gearbox_pkg.sv | 48 ++++
 rtl/byte_shift_buf.sv | 61 ++++++
 rtl/width_gearbox.sv | 107 ++++++++++
 3 files changed

// File: rtl/width_gearbox_pkg.sv
// -----------------------------------------------------------------------------
// width_gearbox_pkg
// Shared helpers for the byte-granular stream width converters.
//   lead_ones(strb, nbits) : count of consecutive ones in strb from bit 0,
//                            looking at the low nbits bits only.
//   byte_mask(n, width)    : vector with the low min(n, width) bits set.
//   GEARBOX_CHECK_WIDTH    : elaboration-time check that a data width is a
//                            positive multiple of 8.
// -----------------------------------------------------------------------------

// Usage inside a module body: `GEARBOX_CHECK_WIDTH(g_label, WIDTH_PARAM)
`define GEARBOX_CHECK_WIDTH(label, w) \
    if ((((w) % 8) != 0) || ((w) < 8)) begin : label \
        $error("gearbox: width %0d is not a positive multiple of 8", (w)); \
    end

package width_gearbox_pkg;

    // Upper bound on strobe / buffer byte counts handled by the helpers.
    localparam int unsigned MAX_BYTES = 64;

    typedef logic [MAX_BYTES-1:0] strb_t;

    function automatic int unsigned lead_ones(input strb_t strb, input int unsigned nbits);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (run && (i < nbits) && strb[i]) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic strb_t byte_mask(input int unsigned n, input int unsigned width);
        strb_t m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < n) && (i < width);
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_shift_buf.sv
// -----------------------------------------------------------------------------
// byte_shift_buf
// IB+OB byte register. In one cycle it can pop OB bytes (shift the whole
// buffer down by OB bytes, zero-filling the top) and append k input bytes
// starting at byte offset offs_i (offset measured after the pop).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (buffer clears to 0)
//   pop_i      : shift down by OB bytes this cycle
//   push_i     : write k_i bytes of din_i at offset offs_i this cycle
//   offs_i     : append position (post-pop byte index)
//   k_i        : number of input bytes to append (0..IB)
//   din_i      : input beat, byte 0 in the LSBs
//   head_o     : lowest OB buffer bytes
// -----------------------------------------------------------------------------
module byte_shift_buf
    import width_gearbox_pkg::*;
#(
    parameter int unsigned IB = 3,
    parameter int unsigned OB = 4,
    parameter int unsigned CW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop_i,
    input  logic              push_i,
    input  logic [CW-1:0]     offs_i,
    input  logic [CW-1:0]     k_i,
    input  logic [IB*8-1:0]   din_i,
    output logic [OB*8-1:0]   head_o
);

    localparam int unsigned NB  = IB + OB;
    localparam int unsigned NBW = NB * 8;

    logic [NBW-1:0] buf_q, buf_d;
    logic [NBW-1:0] kept, ins, wmask;
    logic [NB-1:0]  bmask;

    always_comb begin
        kept  = pop_i ? (buf_q >> (OB * 8)) : buf_q;
        bmask = NB'(byte_mask(32'(k_i), IB)) << offs_i;
        for (int unsigned j = 0; j < NB; j++) begin
            wmask[j*8 +: 8] = {8{bmask[j] & push_i}};
        end
        ins   = NBW'(din_i) << {offs_i, 3'b000};
        buf_d = (kept & ~wmask) | (ins & wmask);
    end

    // NOTE: the data buffer is reset as well because dout must read zero while
    // and after reset; bytes above cnt are otherwise never cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (pop_i || push_i) begin
            buf_q <= buf_d;
        end
    end

    assign head_o = buf_q[OB*8-1:0];

endmodule

// File: rtl/width_gearbox.sv
// -----------------------------------------------------------------------------
// width_gearbox
// Byte-granular valid/ready stream width converter for any pair of widths
// that are multiples of 8. Input bytes (leading run of strobe ones) are packed
// into an IB+OB byte shift buffer and leave as OB-byte words; a packet tail is
// flushed as a partial word with dout_last.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   cen                         : clock enable, freezes everything when low
//   din, din_strb, din_last     : input beat (byte 0 in LSBs)
//   din_valid / din_ready       : input handshake
//   dout, dout_strb, dout_last  : output beat
//   dout_valid / dout_ready     : output handshake
// -----------------------------------------------------------------------------
module width_gearbox
    import width_gearbox_pkg::*;
#(
    parameter int DIN_WIDTH  = 24,
    parameter int DOUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic [DIN_WIDTH-1:0]    din,
    input  logic [DIN_WIDTH/8-1:0]  din_strb,
    input  logic                    din_last,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [DOUT_WIDTH-1:0]   dout,
    output logic [DOUT_WIDTH/8-1:0] dout_strb,
    output logic                    dout_last,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    localparam int unsigned IB = DIN_WIDTH / 8;
    localparam int unsigned OB = DOUT_WIDTH / 8;
    localparam int unsigned NB = IB + OB;
    localparam int unsigned CW = $clog2(NB + 1);

    `GEARBOX_CHECK_WIDTH(g_chk_din, DIN_WIDTH)
    `GEARBOX_CHECK_WIDTH(g_chk_dout, DOUT_WIDTH)

    if (NB > MAX_BYTES) begin : g_chk_size
        $error("width_gearbox: IB+OB exceeds helper limit");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic [CW-1:0] k, popped, offs;
    logic          in_xfer, out_xfer;

    // Ready depends on registers only, so no path from dout_ready to din_ready.
    assign din_ready  = !flush_q && (cnt_q <= CW'(OB));
    assign dout_valid = (cnt_q >= CW'(OB)) || flush_q;
    assign dout_last  = flush_q && (cnt_q <= CW'(OB));
    assign dout_strb  = (cnt_q >= CW'(OB)) ? '1 : OB'(byte_mask(32'(cnt_q), OB));

    assign in_xfer  = cen && din_valid && din_ready;
    assign out_xfer = cen && dout_valid && dout_ready;

    always_comb begin
        // NOTE: every output of this block is assigned before any condition,
        // so no path leaves a value unassigned and no latch is inferred.
        k       = CW'(lead_ones(strb_t'(din_strb), IB));
        popped  = (cnt_q >= CW'(OB)) ? CW'(OB) : cnt_q;
        // Appended bytes land after whatever survives this cycle's pop.
        offs    = out_xfer ? (cnt_q - popped) : cnt_q;
        cnt_d   = in_xfer ? (offs + k) : offs;
        flush_d = flush_q;
        // Set and clear are exclusive: accepting a beat needs flush low,
        // while dout_last needs flush high.
        if (in_xfer && din_last) begin
            flush_d = 1'b1;
        end else if (out_xfer && dout_last) begin
            flush_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    byte_shift_buf #(
        .IB (IB),
        .OB (OB),
        .CW (CW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .pop_i  (out_xfer),
        .push_i (in_xfer),
        .offs_i (offs),
        .k_i    (k),
        .din_i  (din),
        .head_o (dout)
    );

endmodule
